// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches via READ/BUSYWAIT, issues one instruction at a time.
// Optional FETCH_PERF_CNT_EN adds INSTR_COUNT / WAIT_CYCLES saturating performance counters.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                OFFSET_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                RESET,
  output logic [ADDR_W-1:0]   IMEM_ADDR,
  output logic                IMEM_READ,
  input  logic [INSTR_W-1:0]  IMEM_RDATA,
  input  logic                IMEM_BUSYWAIT,
  output logic [INSTR_W-1:0]  INSTR,
  output logic                INSTR_VALID,
  output logic [ADDR_W-1:0]   PC_OUT,
  input  logic                STALL,
  input  logic                JUMP,
  input  logic                BRANCH_EQ,
  input  logic                BRANCH_NE,
  input  logic                ZERO,
  input  logic [OFFSET_W-1:0] OFFSET
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         INSTR_COUNT,
  output logic [31:0]         WAIT_CYCLES
`endif
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  localparam int STEP  = INSTR_W / 8;
  localparam int SHIFT = $clog2(STEP);

  logic [0:0]         state_reg;
  logic [ADDR_W-1:0]  pc_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic               valid_reg;

  logic [ADDR_W-1:0]  seq_pc;
  logic [ADDR_W-1:0]  offset_ext;
  logic [ADDR_W-1:0]  target_pc;
  logic               taken;
  logic [ADDR_W-1:0]  pc_next;

  // Offset counts instructions, so scale to bytes before adding; wrap-around is intentional.
  always_comb begin
    seq_pc     = pc_reg + ADDR_W'(STEP);
    offset_ext = {{(ADDR_W-OFFSET_W){OFFSET[OFFSET_W-1]}}, OFFSET};
    target_pc  = seq_pc + (offset_ext << SHIFT);
    taken      = JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & ~ZERO);
    pc_next    = taken ? target_pc : seq_pc;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_PC;
      instr_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (!IMEM_BUSYWAIT) begin
            instr_reg <= IMEM_RDATA;
            valid_reg <= 1'b1;
            state_reg <= ISSUE;
          end
        end
        default: begin
          if (!STALL) begin
            pc_reg    <= pc_next;
            valid_reg <= 1'b0;
            state_reg <= FETCH;
          end
        end
      endcase
    end
  end

  // READ drops during reset so an in-flight fetch is abandoned immediately.
  assign IMEM_READ   = (state_reg == FETCH) & ~RESET;
  assign IMEM_ADDR   = pc_reg;
  assign PC_OUT      = pc_reg;
  assign INSTR       = instr_reg;
  assign INSTR_VALID = valid_reg;

`ifdef FETCH_PERF_CNT_EN
  logic [1:0] perf_inc;
  assign perf_inc[0] = (state_reg == ISSUE) & ~STALL;
  assign perf_inc[1] = ((state_reg == FETCH) & IMEM_BUSYWAIT) | ((state_reg == ISSUE) & STALL);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
      logic [31:0] cnt_reg;
      always_ff @(posedge CLK) begin
        if (RESET)
          cnt_reg <= '0;
        else if (perf_inc[gi] && (cnt_reg != 32'hFFFF_FFFF))
          cnt_reg <= cnt_reg + 32'd1;
      end
    end
  endgenerate

  assign INSTR_COUNT = g_perf[0].cnt_reg;
  assign WAIT_CYCLES = g_perf[1].cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: sequential fetch, wait states, jumps/branches, stall, reset, wrap.
// A second instance with RESET_PC=0x100 shares the stimulus to check the reset vector parameter.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        busy;
  logic        stall;
  logic        jump;
  logic        beq;
  logic        bne;
  logic        zero;
  logic [7:0]  offset;

  logic [31:0] imem_addr, imem_addr2;
  logic        imem_read, imem_read2;
  logic [31:0] imem_rdata, imem_rdata2;
  logic [31:0] instr, instr2;
  logic        instr_valid, instr_valid2;
  logic [31:0] pc_out, pc_out2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] instr_count, wait_cycles, instr_count2, wait_cycles2;
`endif

  logic [31:0] mem [128];
  int          total_cnt;
  int          pass_cnt;

  assign imem_rdata  = mem[imem_addr[8:2]];
  assign imem_rdata2 = mem[imem_addr2[8:2]];

  fetch_unit dut (
    .CLK(clk), .RESET(reset),
    .IMEM_ADDR(imem_addr), .IMEM_READ(imem_read), .IMEM_RDATA(imem_rdata), .IMEM_BUSYWAIT(busy),
    .INSTR(instr), .INSTR_VALID(instr_valid), .PC_OUT(pc_out),
    .STALL(stall), .JUMP(jump), .BRANCH_EQ(beq), .BRANCH_NE(bne), .ZERO(zero), .OFFSET(offset)
`ifdef FETCH_PERF_CNT_EN
    , .INSTR_COUNT(instr_count), .WAIT_CYCLES(wait_cycles)
`endif
  );

  fetch_unit #(.RESET_PC(32'h100)) dut_rv (
    .CLK(clk), .RESET(reset),
    .IMEM_ADDR(imem_addr2), .IMEM_READ(imem_read2), .IMEM_RDATA(imem_rdata2), .IMEM_BUSYWAIT(busy),
    .INSTR(instr2), .INSTR_VALID(instr_valid2), .PC_OUT(pc_out2),
    .STALL(stall), .JUMP(jump), .BRANCH_EQ(beq), .BRANCH_NE(bne), .ZERO(zero), .OFFSET(offset)
`ifdef FETCH_PERF_CNT_EN
    , .INSTR_COUNT(instr_count2), .WAIT_CYCLES(wait_cycles2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp)
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    else begin
      pass_cnt++;
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    jump = 1'b0; beq = 1'b0; bne = 1'b0; zero = 1'b0; offset = 8'h00;
  endtask

  // From ISSUE at cur, jump so that the next ISSUE is at tgt.
  task automatic jump_from(input logic [31:0] cur, input logic [31:0] tgt);
    logic [31:0] d;
    d = tgt - cur - 32'd4;
    jump = 1'b1; offset = d[9:2];
    tick();
    clear_ctrl();
    tick();
  endtask

  // Expects the DUT in ISSUE at PC 0x10; returns it there afterwards.
  task automatic branch_case(input string tag, input logic j, input logic eq, input logic ne,
                             input logic z, input logic [7:0] off, input logic [31:0] exp);
    jump = j; beq = eq; bne = ne; zero = z; offset = off;
    tick();
    clear_ctrl();
    check(tag, imem_addr, exp);
    tick();
    jump_from(exp, 32'h10);
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h0004_0005;
    mem[1] = 32'h0002_0009;
    mem[2] = 32'hCAFE_0008;

    reset = 1'b1; busy = 1'b0; stall = 1'b0;
    clear_ctrl();
    tick();
    tick();
    check("rst_read",  {31'd0, imem_read}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc",    pc_out, 32'h0);
    check("rst_pc_rv", pc_out2, 32'h100);

    // Sequential zero-wait fetch
    reset = 1'b0;
    #1;
    check("f0_read", {31'd0, imem_read}, 32'd1);
    check("f0_addr", imem_addr, 32'h0);
    tick();
    check("i0_valid", {31'd0, instr_valid}, 32'd1);
    check("i0_instr", instr, 32'h0004_0005);
    check("i0_pc",    pc_out, 32'h0);
    check("i0_read",  {31'd0, imem_read}, 32'd0);
    tick();
    check("f1_valid", {31'd0, instr_valid}, 32'd0);
    check("f1_addr",  imem_addr, 32'h4);
    tick();
    check("i1_valid", {31'd0, instr_valid}, 32'd1);
    check("i1_instr", instr, 32'h0002_0009);
    check("i1_pc",    pc_out, 32'h4);
    tick();

    // Three wait states on the fetch of address 8
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bw%0d_valid", i), {31'd0, instr_valid}, 32'd0);
      check($sformatf("bw%0d_addr", i), imem_addr, 32'h8);
      check($sformatf("bw%0d_read", i), {31'd0, imem_read}, 32'd1);
    end
    busy = 1'b0;
    tick();
    check("bw_valid", {31'd0, instr_valid}, 32'd1);
    check("bw_instr", instr, 32'hCAFE_0008);

    // Move to ISSUE at 0x10 and exercise next-PC rules
    jump_from(32'h8, 32'h10);
    check("at10_pc", pc_out, 32'h10);
    branch_case("jmp_fe",   1'b1, 1'b0, 1'b0, 1'b0, 8'hFE, 32'h0C);
    branch_case("jmp_03",   1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 32'h20);
    branch_case("beq_nt",   1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 32'h14);
    branch_case("beq_tk",   1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 32'h1C);
    branch_case("bne_tk",   1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 32'h1C);
    branch_case("bne_nt",   1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 32'h14);
    branch_case("both_tk",  1'b0, 1'b1, 1'b1, 1'b1, 8'h02, 32'h1C);

    // Five stall cycles with JUMP toggling; release-cycle controls decide
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      jump = i[0]; offset = 8'h80;
      tick();
      check($sformatf("st%0d_instr", i), instr, 32'h1000_0004);
      check($sformatf("st%0d_pc", i), pc_out, 32'h10);
      check($sformatf("st%0d_read", i), {31'd0, imem_read}, 32'd0);
      check($sformatf("st%0d_valid", i), {31'd0, instr_valid}, 32'd1);
    end
    stall = 1'b0; jump = 1'b1; offset = 8'h03;
    tick();
    clear_ctrl();
    check("st_rel_addr", imem_addr, 32'h20);
    tick();
    jump_from(32'h20, 32'h10);

    // Reset in the middle of a waited fetch at 0x40
    jump = 1'b1; offset = 8'd11;
    tick();
    clear_ctrl();
    busy = 1'b1;
    check("mid_addr", imem_addr, 32'h40);
    tick();
    check("mid_valid", {31'd0, instr_valid}, 32'd0);
    reset = 1'b1;
    tick();
    check("mr_pc",    pc_out, 32'h0);
    check("mr_pc_rv", pc_out2, 32'h100);
    check("mr_valid", {31'd0, instr_valid}, 32'd0);
    check("mr_read",  {31'd0, imem_read}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("mr_icnt", instr_count, 32'd0);
    check("mr_wcnt", wait_cycles, 32'd0);
`endif
    busy = 1'b0;
    reset = 1'b0;

    // Negative offset wraps below zero without complaint
    tick();
    jump = 1'b1; offset = 8'h80;
    tick();
    clear_ctrl();
    check("wrap_addr", imem_addr, 32'hFFFF_FE04);
`ifdef FETCH_PERF_CNT_EN
    check("wr_icnt", instr_count, 32'd1);
    check("wr_wcnt", wait_cycles, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
